// File: rtl/lcd_init_ctrl_pkg.sv
// Shared definitions for the LCD init controller.
// Contents: FSM state encoding, LCD opcode constants, small sizing helper.
// LCD_INIT_DELAY_EN adds the post-sleep-out delay state to the encoding.
package lcd_init_ctrl_pkg;

  localparam logic [7:0] LCD_CMD_SLPOUT = 8'h11;
  localparam logic [7:0] LCD_CMD_DISPON = 8'h29;

  typedef enum logic [3:0] {
    ST_RST_HOLD  = 4'd0,
    ST_RST_REL   = 4'd1,
    ST_FETCH     = 4'd2,
    ST_WR_LO     = 4'd3,
    ST_WR_HI     = 4'd4,
    ST_IDLE      = 4'd5,
    ST_USR_SETUP = 4'd6,
    ST_USR_LO    = 4'd7,
    ST_USR_HI    = 4'd8
`ifdef LCD_INIT_DELAY_EN
    ,
    ST_SLP_DLY   = 4'd9
`endif
  } lcd_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_wr.sv
// Write-strobe timer shared by the ROM init path and the user path.
// A start pulse (issued in the setup cycle) runs WR_LOW low-phase cycles
// followed by WR_HIGH high-phase cycles.
// Ports:
//   clk, resetn : clock, async active-low reset
//   start       : begin a strobe sequence on the next cycle
//   busy        : sequence in progress
//   lo_last     : last cycle of the low phase
//   last        : last cycle of the high phase (sequence ends)
module lcd_bus_wr #(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  output logic busy,
  output logic lo_last,
  output logic last
);

  localparam int TOT = WR_LOW + WR_HIGH;
  localparam int CW  = $clog2(TOT + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign busy    = busy_q;
  assign lo_last = busy_q && (cnt_q == CW'(WR_LOW - 1));
  assign last    = busy_q && (cnt_q == CW'(TOT - 1));

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end else if (busy_q) begin
      if (last) busy_d = 1'b0;
      else      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_init_ctrl.sv
// LCD init sequencer and 8080-style bus owner.
// Pulses the panel reset, walks the instruction ROM writing each byte with
// timed strobes, then hands the bus to one user requester (req/ack).
// Optional feature: define LCD_INIT_DELAY_EN to hold SLP_WAIT cycles with
// cs_n high after every sleep-out (8'h11) ROM byte.
// Ports:
//   clk, resetn          : clock, async active-low reset
//   rom_addr / rom_data  : instruction ROM, combinational read
//   usr_req/rs/data/ack  : user write channel, ack pulses per byte
//   init_done            : ROM sequence finished
//   lcd_*                : panel reset, strobes, register select, data bus
module lcd_init_ctrl
  import lcd_init_ctrl_pkg::*;
#(
  parameter int INST_NUM = 13,
  parameter int RST_WAIT = 50000,
  parameter int WR_LOW   = 2,
  parameter int WR_HIGH  = 2,
  parameter int SLP_WAIT = 600000
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       usr_req,
  input  logic       usr_rs,
  input  logic [7:0] usr_data,
  output logic       usr_ack,
  output logic       init_done,
  output logic       lcd_rst_n,
  output logic       lcd_cs_n,
  output logic       lcd_wr_n,
  output logic       lcd_rd_n,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int         DLY_W     = $clog2(max_int(RST_WAIT, SLP_WAIT)) + 1;
  localparam logic [3:0] LAST_ADDR = 4'(INST_NUM - 1);

  lcd_state_e       state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [3:0]       rom_addr_q, rom_addr_d;
  logic             last_q, last_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic             lcd_cs_n_q, lcd_cs_n_d;
  logic             lcd_wr_n_q, lcd_wr_n_d;
  logic             lcd_rst_n_q, lcd_rst_n_d;
  logic             init_done_q, init_done_d;

  logic bus_start, bus_busy, bus_lo_last, bus_last;
  logic load_rom, next_byte;

  lcd_bus_wr #(
    .WR_LOW  (WR_LOW),
    .WR_HIGH (WR_HIGH)
  ) u_bus_wr (
    .clk     (clk),
    .resetn  (resetn),
    .start   (bus_start),
    .busy    (bus_busy),
    .lo_last (bus_lo_last),
    .last    (bus_last)
  );

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    rom_addr_d  = rom_addr_q;
    last_d      = last_q;
    lcd_data_d  = lcd_data_q;
    lcd_rs_d    = lcd_rs_q;
    bus_start   = 1'b0;
    load_rom    = 1'b0;
    next_byte   = 1'b0;

    case (state_q)
      ST_RST_HOLD: begin
        if (dly_q == DLY_W'(RST_WAIT - 1)) begin
          state_d = ST_RST_REL;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      ST_RST_REL: begin
        if (dly_q == DLY_W'(RST_WAIT - 1)) begin
          dly_d    = '0;
          load_rom = 1'b1;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      // The address advances at the start of the strobe so that rom_data
      // already shows the next byte when the high phase ends; this keeps
      // back-to-back bytes gapless with data valid in the setup cycle.
      // last_q remembers that the byte on the bus is the final one.
      ST_FETCH: begin
        if (!bus_busy) begin
          bus_start = 1'b1;
          state_d   = ST_WR_LO;
          last_d    = (rom_addr_q == LAST_ADDR);
          if (rom_addr_q != LAST_ADDR) rom_addr_d = rom_addr_q + 4'd1;
        end
      end
      ST_WR_LO: if (bus_lo_last) state_d = ST_WR_HI;
      ST_WR_HI: begin
        if (bus_last) begin
`ifdef LCD_INIT_DELAY_EN
          if (lcd_data_q == LCD_CMD_SLPOUT) begin
            state_d = ST_SLP_DLY;
            dly_d   = '0;
          end else begin
            next_byte = 1'b1;
          end
`else
          next_byte = 1'b1;
`endif
        end
      end
`ifdef LCD_INIT_DELAY_EN
      ST_SLP_DLY: begin
        if (dly_q == DLY_W'(SLP_WAIT - 1)) begin
          dly_d     = '0;
          next_byte = 1'b1;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
`endif
      ST_IDLE: begin
        if (usr_req) begin
          state_d    = ST_USR_SETUP;
          lcd_data_d = usr_data;
          lcd_rs_d   = usr_rs;
        end
      end
      ST_USR_SETUP: begin
        if (!bus_busy) begin
          bus_start = 1'b1;
          state_d   = ST_USR_LO;
        end
      end
      ST_USR_LO: if (bus_lo_last) state_d = ST_USR_HI;
      ST_USR_HI: if (bus_last) state_d = ST_IDLE;
      default:   state_d = ST_RST_HOLD;
    endcase

    if (next_byte) begin
      if (last_q) state_d  = ST_IDLE;
      else        load_rom = 1'b1;
    end
    if (load_rom) begin
      state_d    = ST_FETCH;
      lcd_data_d = rom_data;
      lcd_rs_d   = 1'b0;
    end

    // Strobe outputs are registered from the next state so they line up
    // with the state they describe and never glitch.
    init_done_d = init_done_q | (state_d == ST_IDLE);
    lcd_rst_n_d = (state_d != ST_RST_HOLD);
    lcd_wr_n_d  = !(state_d inside {ST_WR_LO, ST_USR_LO});
    lcd_cs_n_d  = !(state_d inside {ST_FETCH, ST_WR_LO, ST_WR_HI,
                                    ST_USR_SETUP, ST_USR_LO, ST_USR_HI});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_RST_HOLD;
      dly_q       <= '0;
      rom_addr_q  <= '0;
      last_q      <= 1'b0;
      lcd_data_q  <= '0;
      lcd_rs_q    <= 1'b0;
      lcd_cs_n_q  <= 1'b1;
      lcd_wr_n_q  <= 1'b1;
      lcd_rst_n_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      rom_addr_q  <= rom_addr_d;
      last_q      <= last_d;
      lcd_data_q  <= lcd_data_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_cs_n_q  <= lcd_cs_n_d;
      lcd_wr_n_q  <= lcd_wr_n_d;
      lcd_rst_n_q <= lcd_rst_n_d;
      init_done_q <= init_done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign usr_ack   = (state_q == ST_USR_HI) && bus_last;
  assign init_done = init_done_q;
  assign lcd_rst_n = lcd_rst_n_q;
  assign lcd_cs_n  = lcd_cs_n_q;
  assign lcd_wr_n  = lcd_wr_n_q;
  assign lcd_rd_n  = 1'b1;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_data  = lcd_data_q;

endmodule
